half_duplex_pad_ctrl: RTL and testbench

Sequencer for a single bidirectional pad built from the team's tristate I/O buffer (buffer pins I, T, O; T=1 releases the pad). It accepts a transmit word, drives it serially onto the pad MSB first, releases the pad for a turnaround gap, then samples an equal-length response word from the far end and returns it with a one-cycle valid strobe. It sits between core logic and one IOBUF-style pad and is the receive/turnaround counterpart of the buffer's drive path.

---
 rtl/half_duplex_pad_ctrl.sv | 137 +++++++++++++
 tb/tb_half_duplex_pad_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/half_duplex_pad_ctrl.sv
// Half-duplex sequencer for one tristate pad: drives a word MSB first, releases the pad
// for a turnaround gap, then samples an equal-length response and strobes it out.
module half_duplex_pad_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  BUSY,
  output logic                  PAD_I,
  output logic                  PAD_T,
  input  logic                  PAD_O
);
  // state | meaning
  // IDLE  | pad released, waiting for TX_VALID
  // DRIVE | pad driven with the TX word, MSB first
  // TURN  | pad released, far end takes over the line
  // RECV  | pad released, response sampled mid-bit
  typedef enum logic [1:0] {IDLE, DRIVE, TURN, RECV} state_t;

  localparam int CNT_MAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [BIT_W-1:0] WORD_LOAD  = BIT_W'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [DATA_WIDTH-1:0]   rx_data_d;
  logic                    rx_valid_d;
  logic                    sync_q;

  assign TX_READY = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = RX_DATA;
    rx_valid_d = 1'b0;
    rx_shift   = (rx_sh_q << 1) | DATA_WIDTH'(sync_q);
    case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          state_d = DRIVE;
          tx_sh_d = TX_DATA;
          rx_sh_d = '0;
          cyc_d   = BIT_LOAD;
          bit_d   = WORD_LOAD;
        end
      end
      DRIVE: begin
        if (cyc_q == '0) begin
          cyc_d = BIT_LOAD;
          if (bit_q == '0) begin
            state_d = TURN;
            cyc_d   = TURN_LOAD;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            tx_sh_d = tx_sh_q << 1;
          end
        end else begin
          cyc_d = cyc_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cyc_q == '0) begin
          state_d = RECV;
          cyc_d   = BIT_LOAD;
          bit_d   = WORD_LOAD;
        end else begin
          cyc_d = cyc_q - CNT_W'(1);
        end
      end
      RECV: begin
        // The shift at cycle index BIT_CYCLES/2 takes the synchronizer's copy of the prior cycle.
        if (cyc_q == SAMPLE_CNT) rx_sh_d = rx_shift;
        if (cyc_q == '0) begin
          cyc_d = BIT_LOAD;
          if (bit_q == '0) begin
            state_d    = IDLE;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sync_q   <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      PAD_I    <= 1'b1;
      PAD_T    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      sync_q   <= PAD_O;
      RX_DATA  <= rx_data_d;
      RX_VALID <= rx_valid_d;
      BUSY     <= (state_d != IDLE);
      PAD_T    <= (state_d != DRIVE);
      PAD_I    <= (state_d == DRIVE) ? tx_sh_d[DATA_WIDTH-1] : 1'b1;
    end
  end
endmodule

// File: tb/tb_half_duplex_pad_ctrl.sv
// Randomized bench for half_duplex_pad_ctrl: default and small-parameter instances are
// driven against a cycle-indexed model of the pad waveform and the returned word.
module tb_half_duplex_pad_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       pad_o;
  bit         sel;

  logic       tx_ready0, rx_valid0, busy0, pad_i0, pad_t0;
  logic [7:0] rx_data0;
  logic       tx_ready1, rx_valid1, busy1, pad_i1, pad_t1;
  logic [3:0] rx_data1;

  logic       tx_ready, rx_valid, busy, pad_i, pad_t;
  logic [7:0] rx_data;

  int n_vec = 0;
  int n_err = 0;
  int cur_n = -1;
  int dw = 8, bc = 4, tc = 2;
  logic [7:0] prev_rx = 8'h00;

  always #5 clk = ~clk;

  half_duplex_pad_ctrl u_dut0 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data), .TX_VALID(tx_valid & ~sel),
    .TX_READY(tx_ready0), .RX_DATA(rx_data0), .RX_VALID(rx_valid0), .BUSY(busy0),
    .PAD_I(pad_i0), .PAD_T(pad_t0), .PAD_O(pad_o)
  );

  half_duplex_pad_ctrl #(.DATA_WIDTH(4), .BIT_CYCLES(2), .TURN_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data[3:0]), .TX_VALID(tx_valid & sel),
    .TX_READY(tx_ready1), .RX_DATA(rx_data1), .RX_VALID(rx_valid1), .BUSY(busy1),
    .PAD_I(pad_i1), .PAD_T(pad_t1), .PAD_O(pad_o)
  );

  assign tx_ready = sel ? tx_ready1 : tx_ready0;
  assign rx_valid = sel ? rx_valid1 : rx_valid0;
  assign busy     = sel ? busy1 : busy0;
  assign pad_i    = sel ? pad_i1 : pad_i0;
  assign pad_t    = sel ? pad_t1 : pad_t0;
  assign rx_data  = sel ? {4'h0, rx_data1} : rx_data0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d cycle %0d): got %0h, expected %0h", tag, sel, cur_n, got, exp);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      cur_n    = -1;
      tx_valid = 1'b0;
      pad_o    = 1'($urandom);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_pad_t", pad_t, 1);
      chk("idle_pad_i", pad_i, 1);
      chk("idle_rx_valid", rx_valid, 0);
      chk("idle_rx_hold", rx_data, prev_rx);
    end
  endtask

  // Caller sits in an IDLE cycle; the next edge is acceptance e0. Returns inside the
  // RX_VALID cycle (or right after an aborting reset) so transactions can be chained.
  task automatic txn(input logic [7:0] tx, input logic [7:0] rsp, input bit garble,
                     input bit noise, input int abort_at);
    int d, len, r, j, k;
    logic [7:0] mask;
    d    = dw * bc;
    len  = 2 * d + tc;
    mask = 8'((1 << dw) - 1);
    cur_n = -1;
    chk("pre_ready", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = tx;
    @(posedge clk); #1;
    for (int n = 0; n <= len; n++) begin
      cur_n = n;
      if (n == len) begin
        tx_valid = 1'b0;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      if (n >= d + tc && n < len) begin
        r = n - d - tc;
        j = r / bc;
        k = r % bc;
        pad_o = (!garble || k == bc / 2 - 1) ? rsp[dw-1-j] : 1'($urandom);
      end else begin
        pad_o = garble ? 1'($urandom) : 1'b1;
      end
      if (n < len) begin
        chk("busy", busy, 1);
        chk("ready", tx_ready, 0);
        chk("rx_valid", rx_valid, 0);
        chk("rx_hold", rx_data, prev_rx);
        chk("pad_t", pad_t, (n < d) ? 0 : 1);
        chk("pad_i", pad_i, (n < d) ? 32'(tx[dw-1-n/bc]) : 1);
      end else begin
        chk("end_busy", busy, 0);
        chk("end_ready", tx_ready, 1);
        chk("end_rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, rsp & mask);
        chk("end_pad_t", pad_t, 1);
        chk("end_pad_i", pad_i, 1);
        prev_rx = rsp & mask;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_pad_t", pad_t, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        tx_valid = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          chk("rst_hold_pad_t", pad_t, 1);
          chk("rst_hold_rx_valid", rx_valid, 0);
        end
        rst     = 1'b0;
        prev_rx = 8'h00;
        return;
      end
      if (n < len) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    pad_o    = 1'b1;
    sel      = 1'b0;
    #2;
    chk("rst_pad_t0", pad_t0, 1);
    chk("rst_pad_i0", pad_i0, 1);
    chk("rst_rx_data0", rx_data0, 0);
    chk("rst_rx_valid0", rx_valid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", tx_ready0, 1);
    chk("rst_pad_t1", pad_t1, 1);
    chk("rst_busy1", busy1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_accept_busy", busy0, 0);
    chk("rst_no_accept_pad_t", pad_t0, 1);
    rst      = 1'b0;
    tx_valid = 1'b0;
    idle(2);

    txn(8'hA5, 8'h3C, 1'b0, 1'b0, -1);
    idle(3);
    txn(8'hA5, 8'h3C, 1'b1, 1'b0, -1);
    idle(1);
    txn(8'h01, 8'($urandom), 1'b1, 1'b0, -1);
    txn(8'hFE, 8'($urandom), 1'b1, 1'b0, -1);
    idle(2);
    txn(8'hFF, 8'($urandom), 1'b0, 1'b1, -1);
    idle(2);
    txn(8'($urandom), 8'($urandom), 1'b1, 1'b0, 40);
    idle(3);
    txn(8'hA5, 8'h3C, 1'b1, 1'b1, -1);
    idle(2);
    for (int i = 0; i < 20; i++) begin
      txn(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    sel     = 1'b1;
    dw      = 4;
    bc      = 2;
    tc      = 1;
    prev_rx = 8'h00;
    idle(2);
    txn(8'h09, 8'h06, 1'b0, 1'b0, -1);
    idle(2);
    txn(8'h09, 8'h06, 1'b1, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      txn(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    txn(8'($urandom), 8'($urandom), 1'b1, 1'b0, 7);
    idle(2);
    txn(8'h09, 8'h06, 1'b1, 1'b1, -1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
